updown_counter_n: RTL
=====================

Name: updown_counter_n

Overview:
Parametrised synchronous up/down counter. Successor to the fixed 4-bit toggle-style up/down counter.
- Adds: configurable width and modulus, count enable, synchronous parallel load, wrap/saturate mode, registered boundary pulse, sticky overflow flag.
- Sits between control logic (up/down/load requests) and display/compare logic that consumes the count.

Parameters:
- WIDTH, 4, bit width of the count.
- MAX_COUNT, 15, highest legal count value. Must satisfy 0 < MAX_COUNT <= 2**WIDTH-1; an elaboration-time check rejects any other value.

Ports:
- clock  input  1  rising-edge clock.
- clear_b  input  1  asynchronous active-low reset.
- enable  input  1  count enable; low holds count (load still honoured).
- up  input  1  count-up request; has priority over down.
- down  input  1  count-down request; acted on only when up=0.
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value to load.
- clr_flag  input  1  synchronous clear of the sticky flag.
- count  output  WIDTH  current count, registered.
- dir  output  2  registered direction of the last accepted step: 00 hold, 01 up, 10 down.
- tc  output  1  boundary pulse, registered, one cycle wide.
- ovf_seen  output  1  sticky flag, set by any wrap.

Behaviour:
Reset:
- clear_b low → count=0, dir=00, tc=0, ovf_seen=0 immediately, with no clock required.
- Deassertion takes effect at the next rising edge.
- Reset asserted mid-operation discards any pending step or load.

Direction decode:
- up=1 → UP.
- up=0, down=1 → DOWN.
- both 0 → HOLD.

Next-state priority per rising edge:
1. load=1 → count = min(load_value, MAX_COUNT); dir=00; tc=0. Load ignores enable, up and down.
2. enable=0 or HOLD → count unchanged, dir=00, tc=0.
3. UP with count < MAX_COUNT → count+1, dir=01, tc=0.
4. UP with count == MAX_COUNT:
   - wrap mode → count=0, tc=1, ovf_seen set.
   - saturate mode → count holds at MAX_COUNT, tc=1, ovf_seen unchanged.
   - dir=01 in both modes.
5. DOWN with count > 0 → count-1, dir=10, tc=0.
6. DOWN with count == 0:
   - wrap mode → count=MAX_COUNT, tc=1, ovf_seen set.
   - saturate mode → count holds at 0, tc=1.
   - dir=10 in both modes.

Timing and arithmetic:
- tc is asserted in the cycle after the boundary edge, coincident with the new count, and lasts exactly one cycle unless the boundary is hit again.
- Repeated steps held at a saturated boundary keep tc high on every cycle.
- Latency: every input takes effect on count at the next rising edge. No combinational path from inputs to outputs.
- Arithmetic is WIDTH-bit unsigned. Wrap is to MAX_COUNT/0, not to 2**WIDTH, so intermediate values above MAX_COUNT never appear.
- sat_mode is sampled every edge; changing it mid-count is legal and affects only the current step.

Sticky flag:
- clr_flag clears ovf_seen.
- A wrap on the same edge as clr_flag wins: ovf_seen=1.

Decomposition:
- Package counter_pkg holds:
  - direction encoding constants DIR_HOLD=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10.
  - mode constants MODE_WRAP=0, MODE_SAT=1.
- One combinational sub-module, counter_dir_decode (up, down, enable → 2-bit direction). It is shared with other counter blocks.
- All state stays in updown_counter_n.

Test Plan:
- WIDTH=4, MAX_COUNT=9, clear_b low then high, enable=1, up=1, 12 edges → count 1..9,0,1,2; tc=1 only in the cycle count=0; ovf_seen=1 from that cycle on.
- Same config, count=0, sat_mode=0, up=0, down=1, 3 edges → count 9,8,7; tc=1 only with count=9; dir=10 throughout.
- sat_mode=1, count=9, up=1 for 3 edges → count stays 9, tc=1 for all 3 cycles, ovf_seen stays 0; then down=1 at count 0 for 2 edges → count 0, tc=1.
- load=1, load_value=13 with enable=0 → count=9 (clamped), dir=00, tc=0; load with load_value=5 while up=1 → count=5, load wins.
- Count to 9 then wrap with clr_flag=1 on the wrapping edge → ovf_seen=1; next edge clr_flag=1, no wrap → ovf_seen=0.
- Reset mid-run: count=6, pull clear_b low between edges → count=0, tc=0, dir=00 immediately; first edge after release with up=1 → count=1.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Brief    : Shared direction and mode encodings for counter blocks.
// Revision : 1.0
// ============================================================================
package counter_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_HOLD = 2'b00;
  localparam dir_t DIR_UP   = 2'b01;
  localparam dir_t DIR_DOWN = 2'b10;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_dir_decode.sv
`default_nettype none
// ============================================================================
// Module   : counter_dir_decode
// Brief    : Combinational up/down/enable to step-direction decode.
// Revision : 1.0
// ============================================================================
module counter_dir_decode
  import counter_pkg::*;
(
  input  logic up,
  input  logic down,
  input  logic enable,
  output dir_t dir
);

  // up takes priority over down; a disabled counter never steps
  always_comb begin
    dir = DIR_HOLD;
    if (enable) begin
      if (up) begin
        dir = DIR_UP;
      end else if (down) begin
        dir = DIR_DOWN;
      end
    end
  end

endmodule : counter_dir_decode
`default_nettype wire

// File: rtl/updown_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_n
// Brief    : Parametrised up/down counter with load, wrap/saturate, boundary
//            pulse and sticky wrap flag.
// Revision : 1.0
// ============================================================================
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             enable,
  input  logic             up,
  input  logic             down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       dir,
  output logic             tc,
  output logic             ovf_seen
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  // MAX_COUNT must be non-zero and representable in WIDTH bits
  if (!((MAX_COUNT > 0) && ((MAX_COUNT >> WIDTH) == 0))) begin : g_bad_max_count
    $error("updown_counter_n: MAX_COUNT=%0d illegal for WIDTH=%0d", MAX_COUNT, WIDTH);
  end

  dir_t             w_step_dir;
  logic [WIDTH-1:0] w_next_count;
  dir_t             w_next_dir;
  logic             w_next_tc;
  logic             w_wrap;
  logic             w_next_ovf;

  logic [WIDTH-1:0] r_count;
  dir_t             r_dir;
  logic             r_tc;
  logic             r_ovf_seen;

  counter_dir_decode u_dir_decode (
    .up     (up),
    .down   (down),
    .enable (enable),
    .dir    (w_step_dir)
  );

  always_comb begin
    w_next_count = r_count;
    w_next_dir   = DIR_HOLD;
    w_next_tc    = 1'b0;
    w_wrap       = 1'b0;
    if (load) begin
      w_next_count = (load_value > c_max) ? c_max : load_value;
    end else begin
      case (w_step_dir)
        DIR_UP: begin
          w_next_dir = DIR_UP;
          if (r_count < c_max) begin
            w_next_count = r_count + c_one;
          end else begin
            w_next_tc = 1'b1;
            if (sat_mode != MODE_SAT) begin
              w_next_count = c_zero;
              w_wrap       = 1'b1;
            end
          end
        end
        DIR_DOWN: begin
          w_next_dir = DIR_DOWN;
          if (r_count > c_zero) begin
            w_next_count = r_count - c_one;
          end else begin
            w_next_tc = 1'b1;
            if (sat_mode != MODE_SAT) begin
              w_next_count = c_max;
              w_wrap       = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // a wrap on the clearing edge must still be recorded
    w_next_ovf = w_wrap ? 1'b1 : (clr_flag ? 1'b0 : r_ovf_seen);
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      r_count    <= '0;
      r_dir      <= DIR_HOLD;
      r_tc       <= 1'b0;
      r_ovf_seen <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_dir      <= w_next_dir;
      r_tc       <= w_next_tc;
      r_ovf_seen <= w_next_ovf;
    end
  end

  assign count    = r_count;
  assign dir      = r_dir;
  assign tc       = r_tc;
  assign ovf_seen = r_ovf_seen;

endmodule : updown_counter_n
`default_nettype wire
